// File: rtl/ga_result_uart_tx.sv
// Purpose: serialises one GA result (x, y, fitness) as a 14-byte 8N1 UART frame: A5, X, Y, Z, XOR checksum.
// Latency: start bit on the line the cycle after the FINISHED_i rising edge; frame lasts 140*CLKS_PER_BIT cycles.
// Backpressure: none; a request while a frame is in flight is dropped and latches OVERRUN_o until reset.
module ga_result_uart_tx #(
  parameter int CLKS_PER_BIT = 50
) (
  input  logic        CLK_i,
  input  logic        RST_i,
  input  logic        FINISHED_i,
  input  logic [27:0] X_i,
  input  logic [27:0] Y_i,
  input  logic [27:0] Z_i,
  output logic        UART_TX_o,
  output logic        BUSY_o,
  output logic        DONE_o,
  output logic        OVERRUN_o
);

  // Bit-cell counter only needs to reach CLKS_PER_BIT-1.
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BYTE_LAST = 4'd13;
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic          finished_q;
  logic          req;
  logic [1:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic [27:0]   x_q;
  logic [27:0]   y_q;
  logic [27:0]   z_q;
  logic [7:0]    chk_q;
  logic [31:0]   x_in_ext;
  logic [31:0]   y_in_ext;
  logic [31:0]   z_in_ext;
  logic [31:0]   x_ext;
  logic [31:0]   y_ext;
  logic [31:0]   z_ext;
  logic [7:0]    chk_in;
  logic [7:0]    cur_byte;
  logic          bit_end;

  // Rising-edge detect on the result-valid level.
  always_comb begin
    req     = FINISHED_i & ~finished_q;
    bit_end = (clk_cnt == BIT_LAST);
  end

  // Checksum of the 12 value bytes, formed from the live inputs so it is captured alongside them.
  always_comb begin
    x_in_ext = {4'h0, X_i};
    y_in_ext = {4'h0, Y_i};
    z_in_ext = {4'h0, Z_i};
    chk_in   = x_in_ext[31:24] ^ x_in_ext[23:16] ^ x_in_ext[15:8] ^ x_in_ext[7:0]
             ^ y_in_ext[31:24] ^ y_in_ext[23:16] ^ y_in_ext[15:8] ^ y_in_ext[7:0]
             ^ z_in_ext[31:24] ^ z_in_ext[23:16] ^ z_in_ext[15:8] ^ z_in_ext[7:0];
  end

  // Byte currently on the wire, selected by frame position (values MSB byte first).
  always_comb begin
    x_ext = {4'h0, x_q};
    y_ext = {4'h0, y_q};
    z_ext = {4'h0, z_q};
    case (byte_idx)
      4'd0:    cur_byte = SYNC_BYTE;
      4'd1:    cur_byte = x_ext[31:24];
      4'd2:    cur_byte = x_ext[23:16];
      4'd3:    cur_byte = x_ext[15:8];
      4'd4:    cur_byte = x_ext[7:0];
      4'd5:    cur_byte = y_ext[31:24];
      4'd6:    cur_byte = y_ext[23:16];
      4'd7:    cur_byte = y_ext[15:8];
      4'd8:    cur_byte = y_ext[7:0];
      4'd9:    cur_byte = z_ext[31:24];
      4'd10:   cur_byte = z_ext[23:16];
      4'd11:   cur_byte = z_ext[15:8];
      4'd12:   cur_byte = z_ext[7:0];
      default: cur_byte = chk_q;
    endcase
  end

  // History of FINISHED_i; cleared in reset so a level held across release counts as a new request.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      finished_q <= 1'b0;
    end else begin
      finished_q <= FINISHED_i;
    end
  end

  // Frame sequencer: line level is registered so every bit cell is exactly CLKS_PER_BIT cycles.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state     <= ST_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= 3'd0;
      byte_idx  <= 4'd0;
      x_q       <= 28'd0;
      y_q       <= 28'd0;
      z_q       <= 28'd0;
      chk_q     <= 8'd0;
      UART_TX_o <= 1'b1;
      BUSY_o    <= 1'b0;
      DONE_o    <= 1'b0;
      OVERRUN_o <= 1'b0;
    end else begin
      DONE_o <= 1'b0;
      // A request only counts as dropped while a frame is actually on the wire.
      if (req && BUSY_o) begin
        OVERRUN_o <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (req) begin
            x_q       <= X_i;
            y_q       <= Y_i;
            z_q       <= Z_i;
            chk_q     <= chk_in;
            clk_cnt   <= '0;
            bit_idx   <= 3'd0;
            byte_idx  <= 4'd0;
            UART_TX_o <= 1'b0;
            BUSY_o    <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            clk_cnt   <= '0;
            bit_idx   <= 3'd0;
            UART_TX_o <= cur_byte[0];
            state     <= ST_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              UART_TX_o <= 1'b1;
              state     <= ST_STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              UART_TX_o <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (byte_idx == BYTE_LAST) begin
              byte_idx <= 4'd0;
              BUSY_o   <= 1'b0;
              DONE_o   <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              byte_idx  <= byte_idx + 4'd1;
              UART_TX_o <= 1'b0;
              state     <= ST_START;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          UART_TX_o <= 1'b1;
          BUSY_o    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ga_result_uart_tx.sv
// Bench for ga_result_uart_tx at CLKS_PER_BIT=4: table of frames plus hand sequences for capture,
// back-to-back, level hold, overrun and mid-frame reset. Line is recorded cycle by cycle and
// compared against a waveform built from hand-computed frame bytes.
module tb_ga_result_uart_tx;

  localparam int CPB  = 4;
  localparam int FCYC = 140 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        fin;
  logic [27:0] x;
  logic [27:0] y;
  logic [27:0] z;
  logic        tx;
  logic        busy;
  logic        done;
  logic        ovr;

  always #5 clk = ~clk;

  ga_result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK_i      (clk),
    .RST_i      (rst),
    .FINISHED_i (fin),
    .X_i        (x),
    .Y_i        (y),
    .Z_i        (z),
    .UART_TX_o  (tx),
    .BUSY_o     (busy),
    .DONE_o     (done),
    .OVERRUN_o  (ovr)
  );

  int errors = 0;
  int checks = 0;

  logic tx_rec   [FCYC];
  logic busy_rec [FCYC];
  logic done_rec [FCYC];
  logic done_aft;
  logic busy_aft;
  logic tx_aft;
  int   lat;

  typedef struct packed {
    logic [27:0]  x;
    logic [27:0]  y;
    logic [27:0]  z;
    logic [111:0] frame;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [111:0] act, input logic [111:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for the first start-bit cycle, then records one full frame plus the cycle after.
  task automatic capture_frame;
    lat = 0;
    @(negedge clk);
    while (tx !== 1'b0 && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    if (tx !== 1'b0) check("start_bit_timeout", 112'(tx), 112'(0));
    for (int k = 0; k < FCYC; k++) begin
      tx_rec[k]   = tx;
      busy_rec[k] = busy;
      done_rec[k] = done;
      @(negedge clk);
    end
    done_aft = done;
    busy_aft = busy;
    tx_aft   = tx;
  endtask

  task automatic check_frame(input logic [111:0] frame, input string tag);
    int mism;
    int busy_low;
    int done_hi;
    for (int b = 0; b < 14; b++) begin
      logic [7:0] got;
      logic [7:0] want;
      for (int j = 0; j < 8; j++) got[j] = tx_rec[b*10*CPB + (1+j)*CPB + CPB/2];
      want = frame[111-8*b -: 8];
      check($sformatf("%s_byte%0d", tag, b), 112'(got), 112'(want));
    end
    mism = 0;
    busy_low = 0;
    done_hi = 0;
    for (int k = 0; k < FCYC; k++) begin
      int   bp;
      int   bb;
      int   p;
      logic eb;
      bp = k / CPB;
      bb = bp / 10;
      p  = bp % 10;
      if (p == 0)      eb = 1'b0;
      else if (p == 9) eb = 1'b1;
      else             eb = frame[104 - 8*bb + (p-1)];
      if (tx_rec[k] !== eb) mism++;
      if (busy_rec[k] !== 1'b1) busy_low++;
      if (done_rec[k] !== 1'b0) done_hi++;
    end
    check($sformatf("%s_wave_mismatch_cycles", tag), 112'(mism), 112'(0));
    check($sformatf("%s_busy_low_cycles", tag), 112'(busy_low), 112'(0));
    check($sformatf("%s_done_in_frame", tag), 112'(done_hi), 112'(0));
    check($sformatf("%s_done_after", tag), 112'(done_aft), 112'(1));
    check($sformatf("%s_busy_after", tag), 112'(busy_aft), 112'(0));
    check($sformatf("%s_tx_after", tag), 112'(tx_aft), 112'(1));
  endtask

  task automatic drive_req(input int i);
    @(posedge clk);
    #1;
    x   = vecs[i].x;
    y   = vecs[i].y;
    z   = vecs[i].z;
    fin = 1'b1;
  endtask

  task automatic drop_req;
    @(posedge clk);
    #1;
    fin = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    int rises;
    int bcyc;
    int stray;
    logic prev;

    vecs[0] = '{x: 28'h0010000, y: 28'h0038000, z: 28'h007C000,
                frame: 112'hA5_00010000_00038000_0007C000_45};
    vecs[1] = '{x: 28'h0000000, y: 28'h0000000, z: 28'h0000000,
                frame: 112'hA5_00000000_00000000_00000000_00};
    vecs[2] = '{x: 28'hFFFFFFF, y: 28'hFFFFFFF, z: 28'hFFFFFFF,
                frame: 112'hA5_0FFFFFFF_0FFFFFFF_0FFFFFFF_F0};
    vecs[3] = '{x: 28'h1234567, y: 28'hABCDEF0, z: 28'h0000001,
                frame: 112'hA5_01234567_0ABCDEF0_00000001_99};
    vecs[4] = '{x: 28'h8000000, y: 28'h0000080, z: 28'h5555555,
                frame: 112'hA5_08000000_00000080_05555555_D8};

    rst = 1'b1;
    fin = 1'b0;
    x   = 28'd0;
    y   = 28'd0;
    z   = 28'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx", 112'(tx), 112'(1));
    check("reset_busy", 112'(busy), 112'(0));
    check("reset_done", 112'(done), 112'(0));
    check("reset_ovr", 112'(ovr), 112'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_tx", 112'(tx), 112'(1));
    check("idle_busy", 112'(busy), 112'(0));

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      drive_req(i);
      capture_frame();
      check($sformatf("vec%0d_latency", i), 112'(lat), 112'(1));
      check_frame(vecs[i].frame, $sformatf("vec%0d", i));
      drop_req();
    end

    // Inputs changing after the request edge must not leak into the frame
    drive_req(0);
    fork
      capture_frame();
      begin
        @(posedge clk);
        #1 x = 28'hFFFFFFF;
      end
    join
    check_frame(vecs[0].frame, "capture");
    drop_req();

    // Back-to-back: second request lands on the DONE cycle
    drive_req(3);
    fork
      capture_frame();
      begin
        repeat (3) @(posedge clk);
        #1 fin = 1'b0;
      end
    join
    check_frame(vecs[3].frame, "b2b_first");
    x   = vecs[1].x;
    y   = vecs[1].y;
    z   = vecs[1].z;
    fin = 1'b1;
    capture_frame();
    check("b2b_latency", 112'(lat), 112'(0));
    check("b2b_ovr", 112'(ovr), 112'(0));
    check_frame(vecs[1].frame, "b2b_second");
    drop_req();

    // Level held high: one frame only
    drive_req(2);
    dn = 0;
    rises = 0;
    bcyc = 0;
    prev = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
      if (busy === 1'b1 && prev !== 1'b1) rises++;
      if (busy === 1'b1) bcyc++;
      prev = busy;
    end
    check("hold_done_pulses", 112'(dn), 112'(1));
    check("hold_frames", 112'(rises), 112'(1));
    check("hold_busy_cycles", 112'(bcyc), 112'(FCYC));
    drop_req();

    // Overrun: extra 0->1 during byte 5 is dropped
    check("ovr_before", 112'(ovr), 112'(0));
    drive_req(4);
    fork
      capture_frame();
      begin
        repeat (5*10*CPB + 10) @(posedge clk);
        #1 fin = 1'b0;
        repeat (3) @(posedge clk);
        #1 fin = 1'b1;
      end
    join
    check_frame(vecs[4].frame, "overrun");
    check("ovr_set", 112'(ovr), 112'(1));
    stray = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) stray++;
    end
    check("ovr_no_second_frame", 112'(stray), 112'(0));
    drop_req();
    check("ovr_sticky", 112'(ovr), 112'(1));

    // Mid-frame reset during data bit 1 of 0xA5 (a zero bit), request held across release
    drive_req(0);
    repeat (1 + 9) @(negedge clk);
    check("rst_pre_tx", 112'(tx), 112'(0));
    check("rst_pre_busy", 112'(busy), 112'(1));
    #2;
    rst = 1'b1;
    #1;
    check("rst_abort_tx", 112'(tx), 112'(1));
    check("rst_abort_busy", 112'(busy), 112'(0));
    check("rst_abort_done", 112'(done), 112'(0));
    check("rst_clears_ovr", 112'(ovr), 112'(0));
    x = vecs[2].x;
    y = vecs[2].y;
    z = vecs[2].z;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    capture_frame();
    check("post_reset_latency", 112'(lat), 112'(0));
    check_frame(vecs[2].frame, "post_reset");
    drop_req();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ga_result_uart_tx.md
GA_RESULT_UART_TX -- requirements
Module: ga_result_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 50, meaning clock cycles per UART bit (50 gives 2 MHz at 100 MHz); legal range 2..65535.
REQ-002 SHALL have port CLK_i  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port RST_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port FINISHED_i  input  1  GA result-valid flag, level; a rising edge requests one frame.
REQ-005 SHALL have port X_i  input  28  GA best x, sampled on the FINISHED_i rising edge.
REQ-006 SHALL have port Y_i  input  28  GA best y, sampled on the FINISHED_i rising edge.
REQ-007 SHALL have port Z_i  input  28  GA best fitness, sampled on the FINISHED_i rising edge.
REQ-008 SHALL have port UART_TX_o  output  1  serial line, 8N1, LSB first, idle high.
REQ-009 SHALL have port BUSY_o  output  1  high while a frame is being transmitted.
REQ-010 SHALL have port DONE_o  output  1  one-cycle pulse when a frame completes.
REQ-011 SHALL have port OVERRUN_o  output  1  sticky; set when a request is dropped.

Function
REQ-012 SHALL detect a request in cycle N when FINISHED_i is 1 at edge N and was 0 at edge N-1, using a registered copy of FINISHED_i.
REQ-013 SHALL, on a request while idle, capture X_i/Y_i/Z_i at edge N; input changes after that edge do not affect the frame.
REQ-014 SHALL assert BUSY_o and drive the start bit (UART_TX_o=0) from cycle N+1.
REQ-015 SHALL send a 14-byte frame: 0xA5, X, Y, Z, CHK; each value zero-extended to 32 bits and sent as 4 bytes, MSB byte first.
REQ-016 SHALL compute CHK as the bitwise XOR of the 12 value bytes; 0xA5 is excluded.
REQ-017 SHALL send each byte as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with each bit held exactly CLKS_PER_BIT cycles.
REQ-018 SHALL send bytes back-to-back with no idle gap, so a frame occupies exactly 140*CLKS_PER_BIT cycles from the first start-bit cycle.
REQ-019 SHALL use a state machine IDLE -> START -> DATA (8 bits) -> STOP, then go to START if bytes remain in the frame, else to IDLE.
REQ-020 SHALL, in the cycle after the final stop bit's last cycle, deassert BUSY_o and pulse DONE_o for one cycle; UART_TX_o stays 1.
REQ-021 SHALL ignore a request that arrives while BUSY_o=1 and set OVERRUN_o; the frame in progress is unaffected.
REQ-022 SHALL treat a request in the same cycle DONE_o pulses as an idle request: no overrun, and the new start bit begins the next cycle.
REQ-023 SHALL not retrigger while FINISHED_i is held high; only a new 0->1 transition starts another frame.
REQ-024 SHALL keep the bit counter and byte index wide enough for CLKS_PER_BIT-1 and 13 respectively, with no wrap inside a frame.

Reset
REQ-025 SHALL, while RST_i=1, force UART_TX_o=1, BUSY_o=0, DONE_o=0, OVERRUN_o=0, state IDLE, all counters 0, and the FINISHED_i history register 0.
REQ-026 SHALL abort any frame immediately on RST_i, mid-bit or mid-byte, with no partial stop bit and no DONE_o.
REQ-027 SHALL treat FINISHED_i held high across reset release as a request in the first cycle after release.
REQ-028 SHALL clear OVERRUN_o only by reset.

Verification
REQ-029 SHALL verify nominal frame (CLKS_PER_BIT=4): X=0x0010000, Y=0x0038000, Z=0x007C000, FINISHED 0->1 -> bytes A5 00 01 00 00 00 03 80 00 00 07 C0 00 45; BUSY for 560 cycles; then one DONE_o pulse.
REQ-030 SHALL verify capture: change X_i to 0xFFFFFFF one cycle after the request -> the frame still carries 00 01 00 00.
REQ-031 SHALL verify overrun: FINISHED toggles 0->1->0->1 during byte 5 -> one frame only, unchanged; OVERRUN_o=1 stays set until reset.
REQ-032 SHALL verify level hold: FINISHED held high for 2000 cycles -> exactly one frame and one DONE_o pulse.
REQ-033 SHALL verify mid-frame reset: RST_i pulsed during a data bit -> UART_TX_o=1 and BUSY_o=0 immediately; FINISHED_i still high at release -> full new frame starts with 0xA5.
REQ-034 SHALL verify back-to-back: request coincident with DONE_o -> second frame start bit the next cycle, OVERRUN_o=0.
